spi_master: RTL and testbench

Command-side SPI master that drives the SPI slave / data-memory pair. It accepts 10-bit memory command words (write-address, write-data, read-address, read-data) over a valid/ready handshake. It serialises each word onto `SS_n`/`MOSI` in the frame format the slave decodes. For read-data commands it captures the 8-bit reply from `MISO` and returns it with a one-cycle `rd_valid` strobe.

---
 rtl/spi_master.sv | 120 ++++++++++++
 tb/tb_spi_master.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI command master: serialises 10-bit memory commands onto SS_n/MOSI and returns read bytes from MISO.
// Frame is 13 slots (20+MISO_DLY for reads) plus IDLE_GAP; cmd_ready is high only when idle, so commands wait upstream.
module spi_master #(
  parameter int MISO_DLY = 4,
  parameter int IDLE_GAP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_word,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SEL, ST_CMD, ST_SHIFT, ST_HOLD, ST_WAIT, ST_RECV, ST_GAP
  } state_t;

  localparam logic [3:0] DLY_LAST = 4'(MISO_DLY - 1);
  localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);

  state_t     state_q, state_nxt;
  logic [3:0] cnt_q, cnt_nxt;
  logic [9:0] word_q;
  logic [6:0] shreg_q;
  logic       ss_n_nxt, mosi_nxt;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = ~cmd_ready;

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      ST_IDLE:  if (cmd_valid) state_nxt = ST_SEL;
      ST_SEL:   state_nxt = ST_CMD;
      ST_CMD: begin
        state_nxt = ST_SHIFT;
        cnt_nxt   = '0;
      end
      ST_SHIFT: begin
        if (cnt_q == 4'd9) begin
          state_nxt = (word_q[9:8] == 2'b11) ? ST_WAIT : ST_HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + 4'd1;
        end
      end
      ST_HOLD: begin
        state_nxt = ST_GAP;
        cnt_nxt   = '0;
      end
      ST_WAIT: begin
        if (cnt_q == DLY_LAST) begin
          state_nxt = ST_RECV;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + 4'd1;
        end
      end
      ST_RECV: begin
        if (cnt_q == 4'd7) begin
          state_nxt = ST_GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + 4'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Pins are registered from the next state so each slot's value appears right after its edge
    ss_n_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_GAP);
    mosi_nxt = 1'b0;
    if (state_nxt == ST_CMD)   mosi_nxt = word_q[9];
    if (state_nxt == ST_SHIFT) mosi_nxt = word_q[cnt_nxt];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      word_q   <= '0;
      shreg_q  <= '0;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      SS_n     <= ss_n_nxt;
      MOSI     <= mosi_nxt;
      rd_valid <= 1'b0;
      if (state_q == ST_IDLE && cmd_valid) word_q <= cmd_word;
      // LSB arrives first; the eighth sample completes the byte straight into rd_data
      if (state_q == ST_RECV) begin
        shreg_q <= {MISO, shreg_q[6:1]};
        if (cnt_q == 4'd7) begin
          rd_data  <= {MISO, shreg_q};
          rd_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three instances (MISO_DLY 4, 1, 7) each with a slave/memory model and a frame-level reference.
module tb_spi_master;
  localparam int GAP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [2:0]      cmd_valid, cmd_ready, rd_valid, busy, ss_n, mosi;
  logic [2:0][9:0] cmd_word;
  logic [2:0][7:0] rd_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h (cycle %0d)", nm, g, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int D = (g == 0) ? 4 : (g == 1) ? 1 : 7;
    logic miso = 1'b1;

    spi_master #(.MISO_DLY(D), .IDLE_GAP(GAP)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
      .cmd_word(cmd_word[g]), .rd_data(rd_data[g]), .rd_valid(rd_valid[g]),
      .busy(busy[g]), .SS_n(ss_n[g]), .MOSI(mosi[g]), .MISO(miso)
    );

    // Reference: slot index k within the current frame, host-side view of memory
    bit       act;
    int       k;
    bit [9:0] w;
    bit [7:0] mem [256];
    bit [7:0] wa, ra;
    logic     e_ss, e_mosi, e_busy, e_rdv;
    logic [7:0] e_rd;

    always @(posedge clk) begin
      int len;
      e_rdv = 1'b0;
      if (rst) begin
        act  = 1'b0;
        e_rd = 8'h00;
      end else if (act) begin
        k++;
        len = (w[9:8] == 2'b11) ? 20 + D : 13;
        if (w[9:8] == 2'b11 && k == len + 1) begin
          e_rd  = mem[ra];
          e_rdv = 1'b1;
        end
        if (k == len + GAP + 1) act = 1'b0;
      end else if (cmd_valid[g]) begin
        act = 1'b1;
        k   = 1;
        w   = cmd_word[g];
        case (w[9:8])
          2'b00:   wa = w[7:0];
          2'b01:   mem[wa] = w[7:0];
          2'b10:   ra = w[7:0];
          default: ;
        endcase
      end
      len    = (w[9:8] == 2'b11) ? 20 + D : 13;
      e_ss   = !(act && k <= len);
      e_busy = act;
      e_mosi = !act ? 1'b0 : (k == 2) ? w[9] : (k >= 3 && k <= 12) ? w[k-3] : 1'b0;
    end

    // Slave + memory: decodes MOSI slots 3..12, drives MISO bit i in slot 13+D+i, 1s elsewhere
    bit [7:0]   smem [256];
    bit [7:0]   swa, sra;
    bit [9:0]   srx;
    int         sk;
    bit         srd;
    logic [9:0] rx_last = '0;
    int         rx_cnt  = 0;

    always @(negedge clk) begin
      if (ss_n[g] !== 1'b0) begin
        sk   = 0;
        srd  = 1'b0;
        miso = 1'b1;
      end else begin
        sk++;
        if (sk >= 3 && sk <= 12) srx[sk-3] = mosi[g];
        if (sk == 12) begin
          rx_last = srx;
          rx_cnt++;
          case (srx[9:8])
            2'b00:   swa = srx[7:0];
            2'b01:   smem[swa] = srx[7:0];
            2'b10:   sra = srx[7:0];
            default: srd = 1'b1;
          endcase
        end
        miso = (srd && sk >= 13 + D && sk <= 20 + D) ? smem[sra][sk-13-D] : 1'b1;
      end
    end
  end

  task automatic cmp(input int g, input logic a_ss, a_mosi, a_busy, a_rdy, a_rdv,
                     input logic [7:0] a_rd, input logic x_ss, x_mosi, x_busy, x_rdv,
                     input logic [7:0] x_rd);
    chk("ss_n", g, a_ss, x_ss);
    chk("mosi", g, a_mosi, x_mosi);
    chk("busy", g, a_busy, x_busy);
    chk("cmd_ready", g, a_rdy, !x_busy);
    chk("rd_valid", g, a_rdv, x_rdv);
    chk("rd_data", g, a_rd, x_rd);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, ss_n[0], mosi[0], busy[0], cmd_ready[0], rd_valid[0], rd_data[0],
          inst[0].e_ss, inst[0].e_mosi, inst[0].e_busy, inst[0].e_rdv, inst[0].e_rd);
      cmp(1, ss_n[1], mosi[1], busy[1], cmd_ready[1], rd_valid[1], rd_data[1],
          inst[1].e_ss, inst[1].e_mosi, inst[1].e_busy, inst[1].e_rdv, inst[1].e_rd);
      cmp(2, ss_n[2], mosi[2], busy[2], cmd_ready[2], rd_valid[2], rd_data[2],
          inst[2].e_ss, inst[2].e_mosi, inst[2].e_busy, inst[2].e_rdv, inst[2].e_rd);
    end
  end

  // Returns at the negedge inside slot 1 of the accepted frame
  task automatic send(input int g, input logic [9:0] wd);
    int n = 0;
    cmd_word[g]  = wd;
    cmd_valid[g] = 1'b1;
    while (cmd_ready[g] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", g, cmd_ready[g], 1'b1);
    @(negedge clk);
    cmd_valid[g] = 1'b0;
  endtask

  task automatic wait_rdv(input int g, output int slot);
    slot = 1;
    while (rd_valid[g] !== 1'b1 && slot < 200) begin
      @(negedge clk);
      slot++;
    end
  endtask

  initial begin
    logic [14:0] ss_seq, mo_seq;
    int slot, n, gcnt, t1, t2, c0;

    rst       = 1'b1;
    cmd_valid = '0;
    cmd_word  = '0;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", 0, ss_n[0], 1'b1);
    chk("rst_mosi", 0, mosi[0], 1'b0);
    chk("rst_rd_valid", 0, rd_valid[0], 1'b0);
    chk("rst_rd_data", 0, rd_data[0], 8'h00);
    chk("rst_cmd_ready", 0, cmd_ready[0], 1'b1);
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Write-address frame, pin pattern per slot
    send(0, 10'h0A5);
    ss_seq = '0;
    mo_seq = '0;
    for (int s = 1; s <= 14; s++) begin
      ss_seq[s] = ss_n[0];
      mo_seq[s] = mosi[0];
      @(negedge clk);
    end
    chk("wa_ss_pattern", 0, ss_seq, 15'h4000);
    chk("wa_mosi_pattern", 0, mo_seq, 15'h0528);
    chk("wa_slave_rx", 0, inst[0].rx_last, 10'h0A5);

    // Reset and command in the same cycle: reset wins
    repeat (5) @(negedge clk);
    c0           = inst[0].rx_cnt;
    rst          = 1'b1;
    cmd_word[0]  = 10'h0FF;
    cmd_valid[0] = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    cmd_valid[0] = 1'b0;
    chk("rstcmd_ss_n", 0, ss_n[0], 1'b1);
    chk("rstcmd_ready", 0, cmd_ready[0], 1'b1);
    repeat (15) @(negedge clk);
    chk("rstcmd_no_frame", 0, inst[0].rx_cnt - c0, 0);

    // Reset during RECV slot 3 (frame slot 19 for MISO_DLY=4)
    send(0, 10'h05A);
    send(0, 10'h1FF);
    send(0, 10'h25A);
    send(0, 10'h300);
    repeat (18) @(negedge clk);
    chk("midrst_busy", 0, busy[0], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ss_n", 0, ss_n[0], 1'b1);
    chk("midrst_mosi", 0, mosi[0], 1'b0);
    chk("midrst_rd_valid", 0, rd_valid[0], 1'b0);
    chk("midrst_rd_data", 0, rd_data[0], 8'h00);
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (rd_valid[0] === 1'b1) n++;
    end
    chk("midrst_no_rd_valid", 0, n, 0);
    send(0, 10'h25A);
    send(0, 10'h300);
    wait_rdv(0, slot);
    chk("reread_slot", 0, slot, 25);
    chk("reread_data", 0, rd_data[0], 8'hFF);

    // Full write/read sequence
    send(0, 10'h0A5);
    send(0, 10'h133);
    send(0, 10'h2A5);
    send(0, 10'h300);
    wait_rdv(0, slot);
    chk("seq_slot", 0, slot, 25);
    chk("seq_data", 0, rd_data[0], 8'h33);

    // Back-to-back with cmd_valid held high
    repeat (10) @(negedge clk);
    c0           = inst[0].rx_cnt;
    cmd_word[0]  = 10'h111;
    cmd_valid[0] = 1'b1;
    n = 0;
    while (cmd_ready[0] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    t1          = cyc;
    cmd_word[0] = 10'h122;
    n    = 0;
    gcnt = 0;
    while (cmd_ready[0] !== 1'b1 && n < 100) begin
      if (ss_n[0] === 1'b1 && busy[0] === 1'b1) gcnt++;
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    t2           = cyc;
    cmd_valid[0] = 1'b0;
    chk("b2b_accept_spacing", 0, t2 - t1, 16);
    chk("b2b_gap_cycles", 0, gcnt, GAP);
    repeat (14) @(negedge clk);
    chk("b2b_slave_rx", 0, inst[0].rx_last, 10'h122);
    chk("b2b_frame_count", 0, inst[0].rx_cnt - c0, 2);

    // MISO_DLY sweep on the other two instances
    send(1, 10'h010);
    send(1, 10'h1C3);
    send(1, 10'h210);
    send(1, 10'h300);
    wait_rdv(1, slot);
    chk("dly1_slot", 1, slot, 22);
    chk("dly1_data", 1, rd_data[1], 8'hC3);
    send(2, 10'h010);
    send(2, 10'h1C3);
    send(2, 10'h210);
    send(2, 10'h300);
    wait_rdv(2, slot);
    chk("dly7_slot", 2, slot, 28);
    chk("dly7_data", 2, rd_data[2], 8'hC3);

    repeat (30) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
